// File: rtl/seq_div_32_if.sv
// Handshake and data bundle between the divider and its requester.
interface seq_div_32_if;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/seq_div_32.sv
// Sequential 32-bit signed restoring divider, one quotient bit per clock.
// IDLE: wait for start | CALC: 32 trial-subtract steps | FIX: apply signs, load outputs | DONE: ready pulse
module seq_div_32 (
  input  logic         clock,
  input  logic         reset,
  seq_div_32_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic [32:0] rem;
  logic        sign_q;
  logic        sign_r;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        exception;
  logic        ready;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [32:0] trial;

  // Magnitudes are unsigned, so |0x80000000| is 2^31 with no wrap.
  always_comb begin
    abs_a  = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
    abs_b  = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;
    rem_sh = {rem[31:0], quo[31]};
    trial  = rem_sh - {1'b0, divisor};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 6'd0;
      quo       <= 32'd0;
      divisor   <= 32'd0;
      rem       <= 33'd0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      result    <= 32'd0;
      remainder <= 32'd0;
      exception <= 1'b0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ctrl_div) begin
            quo       <= abs_a;
            divisor   <= abs_b;
            rem       <= 33'd0;
            sign_q    <= bus.data_operandA[31] ^ bus.data_operandB[31];
            sign_r    <= bus.data_operandA[31];
            exception <= 1'b0;
            count     <= 6'd0;
            if (bus.data_operandB == 32'd0) begin
              result    <= 32'd0;
              remainder <= bus.data_operandA;
              exception <= 1'b1;
              ready     <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= trial[32] ? rem_sh : trial;
          quo   <= {quo[30:0], ~trial[32]};
          count <= count + 6'd1;
          if (count == 6'd31) state <= FIX;
        end
        FIX: begin
          result    <= sign_q ? (32'd0 - quo) : quo;
          remainder <= sign_r ? (32'd0 - rem[31:0]) : rem[31:0];
          // A positive quotient of 2^31 only arises from 0x80000000 / -1.
          exception <= ~sign_q & quo[31];
          ready     <= 1'b1;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_result    = result;
  assign bus.data_remainder = remainder;
  assign bus.data_exception = exception;
  assign bus.data_resultRDY = ready;
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_seq_div_32.sv
// Self-checking bench for seq_div_32: directed table, random vs. arithmetic model, timing corners.
module tb_seq_div_32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_div_32_if bus ();

  seq_div_32 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit values.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'd0;
      r = a;
      e = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      e  = (lq > 64'sd2147483647);
    end
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e,
                         output int lat, output logic rdy_after, output logic busy_after);
    @(negedge clock);
    bus.ctrl_div      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1 bus.ctrl_div = 1'b0;
    lat = -1;
    if (bus.data_resultRDY) lat = 0;
    else begin
      for (int i = 1; i <= 40; i++) begin
        @(posedge clock);
        #1;
        if (bus.data_resultRDY) begin
          lat = i;
          break;
        end
      end
    end
    q = bus.data_result;
    r = bus.data_remainder;
    e = bus.data_exception;
    @(posedge clock);
    #1;
    rdy_after  = bus.data_resultRDY;
    busy_after = bus.busy;
  endtask

  task automatic check_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic ee);
    logic [31:0] q, r;
    logic        e, ra, ba;
    int          lat;
    run_div(a, b, q, r, e, lat, ra, ba);
    chk({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd33);
    chk({tag, " result"}, q, eq);
    chk({tag, " remainder"}, r, er);
    chk({tag, " exception"}, {31'd0, e}, {31'd0, ee});
    chk({tag, " ready one cycle"}, {31'd0, ra}, 32'd0);
    chk({tag, " busy after"}, {31'd0, ba}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, mq, mr;
    logic        me;
    int          pulses, first_at, second_at;
    logic [31:0] res1, res2;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    vecs[2]  = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
    vecs[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[4]  = '{32'd5,          32'd0,          32'd0,          32'd5,          1'b1};
    vecs[5]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[6]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b1};
    vecs[7]  = '{32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0};
    vecs[8]  = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0};
    vecs[9]  = '{32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0};
    vecs[10] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[11] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};

    bus.ctrl_div      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    #1;
    chk("reset result", bus.data_result, 32'd0);
    chk("reset remainder", bus.data_remainder, 32'd0);
    chk("reset exception", {31'd0, bus.data_exception}, 32'd0);
    chk("reset ready", {31'd0, bus.data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      check_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e);

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'(-int'($urandom_range(1, 15)));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(a, b, mq, mr, me);
      check_div($sformatf("rand%0d %h/%h", n, a, b), a, b, mq, mr, me);
    end

    // Start pulse while busy must be ignored.
    @(negedge clock);
    bus.ctrl_div = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd10;
    @(posedge clock);
    #1 bus.ctrl_div = 1'b0;
    pulses = 0; first_at = -1; res1 = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 10) begin
        bus.ctrl_div = 1'b1; bus.data_operandA = 32'd1; bus.data_operandB = 32'd1;
      end
      @(posedge clock);
      #1 bus.ctrl_div = 1'b0;
      if (bus.data_resultRDY) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          res1 = bus.data_result;
        end
      end
    end
    chk("ignored start latency", 32'(first_at), 32'd33);
    chk("ignored start pulses", 32'(pulses), 32'd1);
    chk("ignored start result", res1, 32'd100);

    // Reset mid-CALC discards the operation.
    @(negedge clock);
    bus.ctrl_div = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd10;
    @(posedge clock);
    #1 bus.ctrl_div = 1'b0;
    repeat (15) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset result", bus.data_result, 32'd0);
    chk("midreset remainder", bus.data_remainder, 32'd0);
    chk("midreset exception", {31'd0, bus.data_exception}, 32'd0);
    chk("midreset busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) pulses++;
    end
    chk("midreset no ready", 32'(pulses), 32'd0);
    check_div("after reset", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);

    // ctrl_div held high: restarts only from IDLE, so ready pulses are 35 edges apart.
    @(negedge clock);
    bus.ctrl_div = 1'b1; bus.data_operandA = 32'd50; bus.data_operandB = 32'd5;
    @(posedge clock);
    first_at = -1; second_at = -1; res1 = 32'd0; res2 = 32'd0;
    for (int i = 1; i <= 69; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        if (first_at < 0) begin
          first_at = i; res1 = bus.data_result;
        end else if (second_at < 0) begin
          second_at = i; res2 = bus.data_result;
        end
      end
    end
    bus.ctrl_div = 1'b0;
    chk("held start first ready", 32'(first_at), 32'd33);
    chk("held start second ready", 32'(second_at), 32'd68);
    chk("held start result1", res1, 32'd10);
    chk("held start result2", res2, 32'd10);
    repeat (4) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
